// File: rtl/wiener_block_stats_if.sv
// Pixel/noise input bundle and block statistics result bundle
// for wiener_block_stats.
interface wiener_block_stats_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_valid;
  logic                  start_of_block;
  logic                  start_of_frame;
  logic [15:0]           blocks_per_frame;
  logic [15:0]           estimated_noise;
  logic                  noise_valid;
  logic [DATA_WIDTH-1:0] mean_out;
  logic [15:0]           variance_out;
  logic [15:0]           signal_var_out;
  logic                  stats_ready;
  logic [15:0]           block_idx;
  logic                  frame_done;
  logic                  block_err;
  logic                  busy;

  modport master (
    output data_in, data_valid, start_of_block,
    output start_of_frame, blocks_per_frame,
    output estimated_noise, noise_valid,
    input  mean_out, variance_out, signal_var_out,
    input  stats_ready, block_idx, frame_done,
    input  block_err, busy
  );

  modport slave (
    input  data_in, data_valid, start_of_block,
    input  start_of_frame, blocks_per_frame,
    input  estimated_noise, noise_valid,
    output mean_out, variance_out, signal_var_out,
    output stats_ready, block_idx, frame_done,
    output block_err, busy
  );
endinterface

// File: rtl/wiener_block_stats.sv
// Per-block mean / variance / signal variance for the Wiener filter,
// with frame block indexing and protocol error reporting.
module wiener_block_stats #(
  parameter int DATA_WIDTH = 8,
  parameter int BLOCK_SIZE = 8
) (
  input logic clk,
  input logic rst_n,
  wiener_block_stats_if.slave bus
);
  localparam int N    = BLOCK_SIZE * BLOCK_SIZE;
  localparam int LOGN = $clog2(N);
  localparam int SW   = DATA_WIDTH + LOGN;
  localparam int QW   = 2 * DATA_WIDTH + LOGN;
  localparam int DW   = DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE, ACCUM, CALC, OUT
  } state_t;

  state_t          state_q, state_d;
  logic            ph_q, ph_d;
  logic [LOGN-1:0] cnt_q, cnt_d;
  logic [SW-1:0]   sum_q, sum_d;
  logic [QW-1:0]   sq_q, sq_d;
  logic [15:0]     noise_q, noise_d;
  logic [15:0]     blk_q, blk_d;
  logic [DW-1:0]   mean_q, mean_d;
  logic [15:0]     msq_q, msq_d;
  logic [DW-1:0]   mout_q, mout_d;
  logic [15:0]     var_q, var_d;
  logic [15:0]     sig_q, sig_d;
  logic [15:0]     idx_q, idx_d;
  logic            fd_q, fd_d;
  logic            err_q, err_d;

  logic            smp, sob;
  logic [2*DW-1:0] pix_sq, mean_sq;
  logic [15:0]     var_c, blk_inc, bpf_m1;

  assign smp     = bus.data_valid;
  assign sob     = bus.data_valid & bus.start_of_block;
  assign pix_sq  = {{DW{1'b0}}, bus.data_in} * {{DW{1'b0}}, bus.data_in};
  assign mean_sq = {{DW{1'b0}}, mean_q} * {{DW{1'b0}}, mean_q};
  assign var_c   = msq_q - 16'(mean_sq);
  assign blk_inc = blk_q + 16'd1;
  assign bpf_m1  = bus.blocks_per_frame - 16'd1;

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    sq_d    = sq_q;
    noise_d = noise_q;
    blk_d   = blk_q;
    mean_d  = mean_q;
    msq_d   = msq_q;
    mout_d  = mout_q;
    var_d   = var_q;
    sig_d   = sig_q;
    idx_d   = idx_q;
    fd_d    = 1'b0;
    err_d   = 1'b0;
    if (bus.noise_valid) noise_d = bus.estimated_noise;
    unique case (state_q)
      IDLE, OUT: begin
        state_d = IDLE;
        if (sob) begin
          state_d = ACCUM;
          sum_d   = SW'(bus.data_in);
          sq_d    = QW'(pix_sq);
          cnt_d   = LOGN'(1);
          if (bus.start_of_frame) blk_d = '0;
        end
      end
      ACCUM: begin
        if (sob) begin
          err_d = 1'b1;
          sum_d = SW'(bus.data_in);
          sq_d  = QW'(pix_sq);
          cnt_d = LOGN'(1);
          if (bus.start_of_frame) blk_d = '0;
        end else if (smp) begin
          sum_d = sum_q + SW'(bus.data_in);
          sq_d  = sq_q + QW'(pix_sq);
          cnt_d = cnt_q + LOGN'(1);
          if (cnt_q == LOGN'(N - 1)) begin
            state_d = CALC;
            ph_d    = 1'b0;
          end
        end
      end
      CALC: begin
        err_d = smp;
        // two-stage: means first, then the square/subtract/clamp
        if (!ph_q) begin
          ph_d   = 1'b1;
          mean_d = sum_q[SW-1:LOGN];
          msq_d  = 16'(sq_q >> LOGN);
        end else begin
          ph_d    = 1'b0;
          state_d = OUT;
          mout_d  = mean_q;
          var_d   = var_c;
          sig_d   = (var_c > noise_q) ? var_c - noise_q : '0;
          idx_d   = blk_q;
          fd_d    = (bus.blocks_per_frame != '0) &&
                    (blk_q == bpf_m1);
          blk_d   = (blk_inc == bus.blocks_per_frame) ? '0 : blk_inc;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ph_q    <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      sq_q    <= '0;
      noise_q <= '0;
      blk_q   <= '0;
      mean_q  <= '0;
      msq_q   <= '0;
      mout_q  <= '0;
      var_q   <= '0;
      sig_q   <= '0;
      idx_q   <= '0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      sq_q    <= sq_d;
      noise_q <= noise_d;
      blk_q   <= blk_d;
      mean_q  <= mean_d;
      msq_q   <= msq_d;
      mout_q  <= mout_d;
      var_q   <= var_d;
      sig_q   <= sig_d;
      idx_q   <= idx_d;
      fd_q    <= fd_d;
      err_q   <= err_d;
    end
  end

  assign bus.mean_out       = mout_q;
  assign bus.variance_out   = var_q;
  assign bus.signal_var_out = sig_q;
  assign bus.block_idx      = idx_q;
  assign bus.frame_done     = fd_q;
  assign bus.block_err      = err_q;
  assign bus.stats_ready    = (state_q == OUT);
  assign bus.busy           = (state_q != IDLE);
endmodule

// File: tb/tb_wiener_block_stats.sv
// Randomized and directed bench for wiener_block_stats against
// a plain-arithmetic block statistics model.
module tb_wiener_block_stats;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wiener_block_stats_if #(.DATA_WIDTH(8)) bus ();

  wiener_block_stats #(
    .DATA_WIDTH(8),
    .BLOCK_SIZE(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int blk[64];
  int mnoise = 0;
  int mcnt = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.data_valid     = 1'b0;
    bus.start_of_block = 1'b0;
    bus.start_of_frame = 1'b0;
    bus.noise_valid    = 1'b0;
  endtask

  task automatic set_noise(input int nz);
    bus.estimated_noise = 16'(nz);
    bus.noise_valid     = 1'b1;
    tick();
    bus.noise_valid     = 1'b0;
    mnoise = nz;
  endtask

  task automatic drive_partial(input int n);
    for (int i = 0; i < n; i++) begin
      bus.data_in        = 8'($urandom_range(255));
      bus.data_valid     = 1'b1;
      bus.start_of_block = (i == 0);
      tick();
    end
    idle_in();
  endtask

  // Sends blk[] as one block, then checks the result two edges later.
  task automatic run_block(input bit sof, input int gapmax,
                           input bit poke, input int exp_err);
    int sum, sq, m, v, s, eidx, efd, bpf;
    sum = 0;
    sq  = 0;
    for (int i = 0; i < 64; i++) begin
      if (i > 0) begin
        int g;
        g = $urandom_range(gapmax);
        for (int k = 0; k < g; k++) begin
          idle_in();
          tick();
        end
      end
      bus.data_in        = 8'(blk[i]);
      bus.data_valid     = 1'b1;
      bus.start_of_block = (i == 0);
      bus.start_of_frame = (i == 0) && sof;
      tick();
      if (i == 0) chk("sob_err", bus.block_err, exp_err);
      sum += blk[i];
      sq  += blk[i] * blk[i];
    end
    idle_in();
    if (sof) mcnt = 0;
    m = sum / 64;
    v = sq / 64 - m * m;
    s = (v > mnoise) ? v - mnoise : 0;
    bpf  = bus.blocks_per_frame;
    eidx = mcnt;
    efd  = (bpf != 0 && mcnt == bpf - 1);
    mcnt = ((mcnt + 1) == bpf) ? 0 : ((mcnt + 1) & 16'hffff);
    if (poke) begin
      bus.data_in    = 8'd255;
      bus.data_valid = 1'b1;
    end
    tick();
    idle_in();
    if (poke) chk("calc_err", bus.block_err, 1);
    chk("rdy_early", bus.stats_ready, 0);
    tick();
    chk("rdy", bus.stats_ready, 1);
    chk("mean", bus.mean_out, m);
    chk("var", bus.variance_out, v);
    chk("sig", bus.signal_var_out, s);
    chk("idx", bus.block_idx, eidx);
    chk("fdone", bus.frame_done, efd);
  endtask

  initial begin
    int m0;
    idle_in();
    bus.data_in          = '0;
    bus.estimated_noise  = '0;
    bus.blocks_per_frame = 16'd0;
    #12;
    chk("rst_mean", bus.mean_out, 0);
    chk("rst_var", bus.variance_out, 0);
    chk("rst_sig", bus.signal_var_out, 0);
    chk("rst_idx", bus.block_idx, 0);
    chk("rst_rdy", bus.stats_ready, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    tick();

    // stray samples without start_of_block are ignored in IDLE
    for (int i = 0; i < 3; i++) begin
      bus.data_in    = 8'd200;
      bus.data_valid = 1'b1;
      tick();
    end
    idle_in();
    chk("idle_busy", bus.busy, 0);

    foreach (blk[i]) blk[i] = 100;
    run_block(1'b1, 0, 1'b0, 0);
    m0 = bus.mean_out;
    repeat (3) tick();
    chk("hold_mean", bus.mean_out, m0);
    chk("rdy_drop", bus.stats_ready, 0);

    set_noise(1000);
    foreach (blk[i]) blk[i] = (i % 2) ? 254 : 0;
    run_block(1'b0, 2, 1'b0, 0);
    tick();

    set_noise(500);
    foreach (blk[i]) blk[i] = i;
    run_block(1'b0, 0, 1'b1, 0);
    tick();

    drive_partial(10);
    foreach (blk[i]) blk[i] = 7;
    run_block(1'b0, 0, 1'b0, 1);
    tick();
    chk("err_pulse", bus.block_err, 0);

    // frames of back-to-back blocks
    bus.blocks_per_frame = 16'd4;
    set_noise($urandom_range(3000));
    for (int b = 0; b < 4; b++) begin
      foreach (blk[i]) blk[i] = $urandom_range(255);
      run_block(b == 0, 0, 1'b0, 0);
    end
    tick();
    for (int f = 0; f < 4; f++) begin
      int nb;
      nb = $urandom_range(4, 1);
      bus.blocks_per_frame = 16'(nb);
      set_noise($urandom_range(8000));
      for (int b = 0; b < nb + 1; b++) begin
        foreach (blk[i]) blk[i] = $urandom_range(255, $urandom_range(200));
        run_block(b == 0, $urandom_range(2), 1'b0, 0);
        if ($urandom_range(1) == 1) tick();
      end
      tick();
    end

    // reset mid-block discards it
    drive_partial(30);
    rst_n = 1'b0;
    #2;
    chk("mr_mean", bus.mean_out, 0);
    chk("mr_var", bus.variance_out, 0);
    chk("mr_sig", bus.signal_var_out, 0);
    chk("mr_idx", bus.block_idx, 0);
    chk("mr_busy", bus.busy, 0);
    tick();
    rst_n = 1'b1;
    mnoise = 0;
    mcnt = 0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 80; i++) begin
        tick();
        if (bus.stats_ready) seen = 1;
      end
      chk("mr_no_rdy", seen, 0);
    end
    bus.blocks_per_frame = 16'd0;
    foreach (blk[i]) blk[i] = $urandom_range(255);
    run_block(1'b0, 1, 1'b0, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wiener_block_stats.md
WIENER_BLOCK_STATS -- requirements
Module: wiener_block_stats

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter BLOCK_SIZE, default 8; one block is BLOCK_SIZE*BLOCK_SIZE samples, and that count SHALL be a power of 2.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port data_in, input, DATA_WIDTH bits, RGB-mean pixel of the current block.
REQ-006 SHALL have port data_valid, input, 1 bit; data_in is sampled on the edge where data_valid is high.
REQ-007 SHALL have port start_of_block, input, 1 bit, pulse coincident with the first valid pixel of a block.
REQ-008 SHALL have port start_of_frame, input, 1 bit, pulse coincident with start_of_block of the first block of a frame.
REQ-009 SHALL have port blocks_per_frame, input, 16 bits, number of blocks in a frame.
REQ-010 SHALL have port estimated_noise, input, 16 bits, noise variance from noise_estimation.
REQ-011 SHALL have port noise_valid, input, 1 bit; estimated_noise is latched into noise_reg on the edge where noise_valid is high.
REQ-012 SHALL have port mean_out, output, DATA_WIDTH bits, block mean.
REQ-013 SHALL have port variance_out, output, 16 bits, block variance.
REQ-014 SHALL have port signal_var_out, output, 16 bits, variance minus noise, clamped at 0.
REQ-015 SHALL have port stats_ready, output, 1 bit, one-cycle pulse marking the outputs valid.
REQ-016 SHALL have port block_idx, output, 16 bits, index of the last completed block within the frame.
REQ-017 SHALL have port frame_done, output, 1 bit, one-cycle pulse on the last block of a frame.
REQ-018 SHALL have port block_err, output, 1 bit, one-cycle pulse on a protocol violation.
REQ-019 SHALL have port busy, output, 1 bit, high in any state other than IDLE.

Function
REQ-020 SHALL implement the states IDLE, ACCUM, CALC and OUT.
REQ-021 SHALL keep N=BLOCK_SIZE^2 and a sample counter of log2(N) bits, a sum register of DATA_WIDTH+log2(N) bits, and a sum-of-squares register of 2*DATA_WIDTH+log2(N) bits.
REQ-022 IDLE/OUT: when data_valid and start_of_block are both high, SHALL load sum=data_in, sumsq=data_in^2 and count=1, then go to ACCUM.
REQ-023 IDLE: when data_valid is high without start_of_block, SHALL ignore the sample and leave state unchanged.
REQ-024 ACCUM: on each data_valid, SHALL accumulate the sample and increment count; when the accepted sample is the Nth, SHALL go to CALC.
REQ-025 ACCUM: when start_of_block arrives with data_valid before N samples, SHALL discard the partial block, pulse block_err, and restart with this sample as the first.
REQ-026 CALC: SHALL compute mean = sum>>log2(N), msq = sumsq>>log2(N) and var = msq - mean^2, where mean is the truncated mean; var SHALL always be non-negative and fit in 16 bits.
REQ-027 CALC: SHALL compute signal_var = (var > noise_reg) ? var-noise_reg : 0, using the noise_reg value held before this edge.
REQ-028 SHALL register mean_out, variance_out and signal_var_out on the CALC->OUT edge and hold them until the next OUT.
REQ-029 SHALL assert stats_ready during the whole OUT cycle, which is the cycle after the 2nd rising edge following the edge that accepts the Nth sample; this gives fixed 2-cycle latency.
REQ-030 OUT: SHALL go to ACCUM if a new block starts (REQ-022), otherwise to IDLE, so that back-to-back blocks are supported.
REQ-031 CALC: SHALL drop any data_valid sample and pulse block_err.
REQ-032 SHALL maintain a block counter: start_of_frame clears it to 0 for the block that starts on that edge; each entry into OUT updates block_idx with the index of the completed block and then increments the counter.
REQ-033 SHALL pulse frame_done together with stats_ready when the completed block's index equals blocks_per_frame-1.
REQ-034 When blocks_per_frame=0, SHALL never assert frame_done.
REQ-035 After the last block of a frame (when the counter reaches blocks_per_frame), SHALL set the counter to 0.
REQ-036 SHALL let noise_valid update noise_reg in any state.

Reset
REQ-037 When rst_n is low, SHALL immediately force state=IDLE and clear count, sum, sumsq, noise_reg, the block counter, mean_out, variance_out, signal_var_out, block_idx, stats_ready, frame_done, block_err and busy to 0.
REQ-038 A reset asserted mid-block SHALL discard the partial block, and no stats_ready SHALL follow it.

Verification
REQ-039 Block of 64 samples all equal to 100, noise_reg=0 -> mean_out=100, variance_out=0, signal_var_out=0; stats_ready high in the cycle after the 2nd edge following the 64th sample.
REQ-040 Block alternating 0/254, noise=1000 -> mean_out=127, variance_out=16129, signal_var_out=15129.
REQ-041 Ramp 0..63, noise=500 -> mean_out=31, variance_out=372, signal_var_out=0 (clamped).
REQ-042 start_of_block after 10 samples, followed by a block of 64 samples all equal to 7 -> block_err pulses once, then mean_out=7 and variance_out=0.
REQ-043 blocks_per_frame=4, four back-to-back blocks starting with start_of_frame -> block_idx=0,1,2,3; frame_done only with the 4th stats_ready; no idle cycles are required between blocks.
REQ-044 rst_n low after 30 samples, then released -> all outputs are 0 and no stats_ready appears.
